// File: rtl/imem_loader_pkg.sv
// Shared processor package: IMem geometry constants and the loader state encoding.
// The RX_CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 12;
    localparam int INSTR_W     = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_HI   = 3'd1,
        RX_LO   = 3'd2,
        WRITE   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        RX_CSUM = 3'd4,
`endif
        DONE    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, IMem write port and status lines of the instruction-memory loader.
// The slave modport is the loader; the master modport is the byte source / system side.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W
);
    logic              start;
    logic [ADDR_W-1:0] word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Loads 16-bit instruction words (high byte first) from a byte stream into IMem from address 0,
// holding the CPU in reset meanwhile. Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rx_state;
    logic              xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              error_q, error_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wdata_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            error_q     <= error_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        error_d     = error_q;
        rx_state    = (state_q == RX_HI) || (state_q == RX_LO) || (state_q == RX_CSUM);
`else
        rx_state    = (state_q == RX_HI) || (state_q == RX_LO);
`endif
        xfer        = rx_state && bus.byte_valid;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // A zero count means a full-depth load, hence the extra counter bit.
                    remaining_d = (bus.word_count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                         : {1'b0, bus.word_count};
                    addr_d      = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = '0;
                    error_d     = 1'b0;
`endif
                    state_d     = RX_HI;
                end
            end
            RX_HI: begin
                if (xfer) begin
                    wdata_d[DATA_W-1 -: 8] = bus.byte_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.byte_data;
`endif
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                if (xfer) begin
                    wdata_d[7:0] = bus.byte_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.byte_data;
`endif
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - (ADDR_W + 1)'(1);
                if (remaining_q == (ADDR_W + 1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = RX_CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RX_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            RX_CSUM: begin
                if (xfer) begin
                    error_d = ((sum_q + bus.byte_data) != 8'h00);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Every output is a register or a decode of state_q; inputs never reach outputs directly.
    assign bus.byte_ready = rx_state;
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
    assign bus.cpu_hold   = (state_q != IDLE) && (state_q != DONE);
    assign bus.done       = (state_q == DONE);
`ifdef LOADER_CHECKSUM_EN
    assign bus.error      = error_q;
`else
    assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, basic/backpressure/full-depth loads, start while busy,
// and the trailing checksum when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   nxfer = 0;
    int   rdy_in_wr = 0;
    logic [11:0] wa_q[$];
    logic [15:0] wd_q[$];

    imem_loader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    imem_loader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/transfer log sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            if (bus.byte_ready) rdy_in_wr++;
        end
        if (bus.byte_valid && bus.byte_ready) nxfer++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [11:0] wc);
        bus.word_count = wc;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.byte_ready) check("send_ready_timeout", bus.byte_ready, 1);
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int max_gap);
        repeat ($urandom_range(0, max_gap)) tick();
        send_byte(w[15:8]);
        repeat ($urandom_range(0, max_gap)) tick();
        send_byte(w[7:0]);
    endtask

    task automatic wait_done(input int max_cyc);
        int t = 0;
        while (!bus.done && t < max_cyc) begin
            tick();
            t++;
        end
        check("done_reached", bus.done, 1);
    endtask

    initial begin
        logic [15:0] bp_words [4];
        logic [15:0] sb_words [3];
        logic [15:0] w;
        int c0, x0, bad;

        bp_words = '{16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
        sb_words = '{16'hA001, 16'hB002, 16'hC003};
        rst = 1'b0;
        bus.start = 1'b0;
        bus.word_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_cpu_hold", bus.cpu_hold, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_state", dut.state_q, IDLE);
        rst = 1'b1;
        tick();

        // Reset mid-load after one byte
        pulse_start(12'd2);
        send_byte(8'h77);
        check("mid_state_rx_lo", dut.state_q, RX_LO);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_state", dut.state_q, IDLE);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_hold", bus.cpu_hold, 0);
        check("mid_rst_ready", bus.byte_ready, 0);
        check("mid_rst_wdata", bus.mem_wdata, 0);
        tick();
        check("mid_rst_no_write", wa_q.size(), 0);
        rst = 1'b1;
        tick();
        check("post_rst_idle_we", bus.mem_we, 0);

        // Basic load 12 34 AB CD
        wa_q.delete(); wd_q.delete();
        pulse_start(12'd2);
        c0 = cyc;
        check("start_busy", bus.busy, 1);
        check("start_hold", bus.cpu_hold, 1);
        check("start_ready", bus.byte_ready, 1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        wait_done(10);
        check("basic_cycles", cyc - c0, 6);
        check("basic_nwrites", wa_q.size(), 2);
        check("basic_a0", wa_q[0], 0);
        check("basic_d0", wd_q[0], 16'h1234);
        check("basic_a1", wa_q[1], 1);
        check("basic_d1", wd_q[1], 16'hABCD);
        check("basic_hold_off", bus.cpu_hold, 0);
        check("basic_busy_off", bus.busy, 0);
`ifndef LOADER_CHECKSUM_EN
        check("basic_error", bus.error, 0);
`endif

        // Bytes offered in DONE are ignored
        x0 = nxfer;
        bus.byte_valid = 1'b1; bus.byte_data = 8'hEE;
        repeat (3) tick();
        check("done_ready_low", bus.byte_ready, 0);
        bus.byte_valid = 1'b0;
        check("done_no_xfer", nxfer - x0, 0);
        check("done_state", dut.state_q, DONE);
        check("done_no_write", wa_q.size(), 2);

        // Backpressure, 4 words
        wa_q.delete(); wd_q.delete();
        x0 = nxfer;
        pulse_start(12'd4);
        check("bp_done_cleared", bus.done, 0);
        for (int i = 0; i < 4; i++) send_word(bp_words[i], 3);
        wait_done(20);
        check("bp_xfers", nxfer - x0, 8);
        check("bp_nwrites", wa_q.size(), 4);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (wa_q[i] !== 12'(i) || wd_q[i] !== bp_words[i]) bad++;
        check("bp_writes_ok", bad, 0);

        // Start while busy: second start must be ignored
        wa_q.delete(); wd_q.delete();
        pulse_start(12'd3);
        send_byte(sb_words[0][15:8]);
        pulse_start(12'd5);
        check("sb_still_busy", bus.busy, 1);
        check("sb_state", dut.state_q, RX_LO);
        send_byte(sb_words[0][7:0]);
        for (int i = 1; i < 3; i++) send_word(sb_words[i], 0);
        wait_done(10);
        repeat (3) tick();
        check("sb_nwrites", wa_q.size(), 3);
        bad = 0;
        for (int i = 0; i < 3; i++)
            if (wa_q[i] !== 12'(i) || wd_q[i] !== sb_words[i]) bad++;
        check("sb_writes_ok", bad, 0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good: 01 02 FD
        wa_q.delete(); wd_q.delete();
        pulse_start(12'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'hFD);
        wait_done(10);
        check("cs_good_error", bus.error, 0);
        check("cs_good_wdata", wd_q[0], 16'h0102);
        // Checksum bad: 01 02 FE
        pulse_start(12'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'hFE);
        wait_done(10);
        check("cs_bad_error", bus.error, 1);
        check("cs_bad_done", bus.done, 1);
        pulse_start(12'd1);
        check("cs_error_cleared", bus.error, 0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_done(10);
`endif

        // Full depth: word_count=0 -> 4096 words
        wa_q.delete(); wd_q.delete();
        pulse_start(12'd0);
        for (int i = 0; i < 4096; i++) begin
            w = 16'((i * 37 + 11) ^ (i << 5));
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_done(10);
        repeat (2) tick();
        check("full_nwrites", wa_q.size(), 4096);
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            w = 16'((i * 37 + 11) ^ (i << 5));
            if (wa_q[i] !== 12'(i) || wd_q[i] !== w) bad++;
        end
        check("full_writes_ok", bad, 0);
        check("full_addr_wrapped", bus.mem_addr, 0);
        check("full_hold_off", bus.cpu_hold, 0);

        check("ready_low_in_write", rdy_in_wr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
